frg_eval_arbiter: RTL and testbench
===================================

Name: frg_eval_arbiter

Overview:
- Sequencer and round-robin arbiter that shares one combinational MCNC-style evaluation core (frg-class: 28 inputs, 3 outputs) among several requesters.
- Accepts one input vector at a time and drives it onto the core's inputs.
- Holds the vector for a programmable settle time, samples the core outputs, and returns them tagged with the requester index.
- Sits between the benchmark harness/requester agents and the shared core instance.

Parameters:
- NREQ, 4, number of requesters (2..16).
- IN_W, 28, core input vector width.
- OUT_W, 3, core output width.
- SETTLE, 2, cycles core_in is held stable before core_out is sampled (>=1).
- IDW, $clog2(NREQ), requester-index width (derived).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_vec  in  NREQ*IN_W  per-requester vector; requester i occupies bits [i*IN_W +: IN_W].
- req_ready  out  NREQ  one-hot grant/accept; combinational, only in IDLE.
- core_in  out  IN_W  registered vector driven to the shared core.
- core_out  in  OUT_W  combinational result from the core.
- rsp_valid  out  1  response valid.
- rsp_id  out  IDW  index of the requester being answered.
- rsp_data  out  OUT_W  sampled core_out.
- rsp_ready  in  1  response consumer ready.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync-free deassert), applied immediately whatever the state, aborting any in-flight transaction:
  - core_in=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, req_ready=0.
  - state=IDLE, rr_ptr=0, settle counter=0.
- States: IDLE, WAIT, RESP.
- IDLE:
  - Choose the winner: the first asserted req_valid at or after rr_ptr, searching upward with wrap from NREQ-1 to 0.
  - Assert req_ready[winner] in the same cycle; transfer occurs on that edge.
  - On transfer: core_in<=req_vec[winner], grant_id<=winner, cnt<=SETTLE-1, go to WAIT.
  - With no req_valid: req_ready=0, core_in holds its last value, stay in IDLE.
- WAIT:
  - If cnt!=0, decrement cnt.
  - If cnt==0: rsp_data<=core_out, rsp_id<=grant_id, rsp_valid<=1, go to RESP.
  - core_in is stable for exactly SETTLE cycles before the sample edge.
- RESP:
  - rsp_valid=1; rsp_id and rsp_data are held stable until rsp_ready=1.
  - On the handshake: rsp_valid<=0, rr_ptr<=(grant_id+1) mod NREQ, go to IDLE.
- Timing:
  - Transfer at cycle t gives rsp_valid high at t+SETTLE+1.
  - Back-to-back period with rsp_ready held high is SETTLE+2 cycles.
- req_ready is zero outside IDLE. Requests raised or dropped during WAIT/RESP are ignored and never lost by the block (requester keeps valid high).
- Exactly one requester is accepted per transaction; at most one bit of req_ready is set.
- Pointer wrap: when grant_id=NREQ-1, the next rr_ptr is 0.
- A requester dropping req_valid before its grant is never granted that cycle; the arbiter does not latch stale requests.
- core_in changes only on transfer or reset; it never glitches during WAIT or RESP.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0; no requester waits more than NREQ-1 transactions.

Test Plan (NREQ=4, SETTLE=2, core modelled as frg function):
- Reset: hold rst_n=0 mid-WAIT with vector 28'h0ABCDEF loaded -> all outputs 0 immediately; after release, busy=0 and rr_ptr=0 (first grant from all-valid goes to 0).
- Single request: req_valid=4'b0100, vec2=28'h0000001 at cycle 0 -> req_ready=4'b0100 at cycle 0; rsp_valid at cycle 3 with rsp_id=2 and rsp_data=frg(28'h0000001).
- Round-robin: req_valid=4'b1111 held, rsp_ready=1 -> grant order 0,1,2,3,0, one grant every 4 cycles.
- Wrap and skip: grant to 3 completes, then only req_valid[1]=1 -> next grant to 1 (pointer wraps to 0; 0 is not requesting, so 1 wins).
- Backpressure: rsp_ready=0 for 5 cycles in RESP while req_valid=4'b0011 -> rsp_valid, rsp_id and rsp_data are stable, req_ready=0 and core_in unchanged; the grant happens in the cycle after rsp_ready=1.
- Settle check: core_out model delayed 1 cycle relative to core_in with SETTLE=2 -> sampled value equals the settled result, never the previous vector's result.

Source files
------------

// File: rtl/frg_eval_arbiter_if.sv
// rtl/frg_eval_arbiter_if.sv - requester, core and response signals of the evaluation arbiter
// The slave modport is the arbiter's view; master is the harness/core side.
interface frg_eval_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int IN_W  = 28,
  parameter int OUT_W = 3,
  parameter int IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*IN_W-1:0] req_vec;
  logic [NREQ-1:0]      req_ready;
  logic [IN_W-1:0]      core_in;
  logic [OUT_W-1:0]     core_out;
  logic                 rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic [OUT_W-1:0]     rsp_data;
  logic                 rsp_ready;
  logic                 busy;

  modport slave (
    input  req_valid, req_vec, core_out, rsp_ready,
    output req_ready, core_in, rsp_valid, rsp_id, rsp_data, busy
  );

  modport master (
    output req_valid, req_vec, core_out, rsp_ready,
    input  req_ready, core_in, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/frg_eval_arbiter.sv
// rtl/frg_eval_arbiter.sv - round-robin sequencer sharing one combinational evaluation core
// Grants one requester, holds its vector on the core for SETTLE cycles, returns the sampled result.
module frg_eval_arbiter #(
  parameter int NREQ   = 4,
  parameter int IN_W   = 28,
  parameter int OUT_W  = 3,
  parameter int SETTLE = 2,
  parameter int IDW    = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  frg_eval_arbiter_if.slave   bus
);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant_id;
  logic [CW-1:0]    cnt;
  logic [IN_W-1:0]  core_in_r;
  logic             rsp_valid_r;
  logic [IDW-1:0]   rsp_id_r;
  logic [OUT_W-1:0] rsp_data_r;

  logic             found;
  logic [IDW-1:0]   winner;
  logic [NREQ-1:0]  grant_vec;
  int               idx;

  // First valid requester at or after rr_ptr, wrapping past NREQ-1.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  always_comb begin
    grant_vec = '0;
    if (rst_n && state == IDLE && found) grant_vec[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      cnt         <= '0;
      core_in_r   <= '0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= '0;
      rsp_data_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            core_in_r <= bus.req_vec[int'(winner)*IN_W +: IN_W];
            grant_id  <= winner;
            cnt       <= CW'(SETTLE - 1);
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_data_r  <= bus.core_out;
            rsp_id_r    <= grant_id;
            rsp_valid_r <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            rr_ptr      <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = grant_vec;
  assign bus.core_in   = core_in_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_data  = rsp_data_r;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_frg_eval_arbiter.sv
// tb/tb_frg_eval_arbiter.sv - directed self-checking bench for frg_eval_arbiter
module tb_frg_eval_arbiter;
  localparam int NREQ   = 4;
  localparam int IN_W   = 28;
  localparam int OUT_W  = 3;
  localparam int SETTLE = 2;
  localparam int IDW    = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  frg_eval_arbiter_if #(.NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W), .IDW(IDW)) bus ();

  frg_eval_arbiter #(.NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SETTLE), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [OUT_W-1:0] frg(input logic [IN_W-1:0] v);
    logic [OUT_W-1:0] o;
    o[0] = ^v;
    o[1] = |(v[27:20] & v[7:0]);
    o[2] = (v[15:8] > v[23:16]);
    return o;
  endfunction

  logic            delay_mode;
  logic [IN_W-1:0] core_in_q;
  logic [IN_W-1:0] vecs [NREQ];

  always @(posedge clk) core_in_q <= bus.core_in;
  assign bus.core_out = frg(delay_mode ? core_in_q : bus.core_in);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vecs();
    for (int i = 0; i < NREQ; i++) bus.req_vec[i*IN_W +: IN_W] = vecs[i];
  endtask

  // Full transaction with rsp_ready held high: grant, SETTLE wait, response, handshake.
  task automatic txn(input int id);
    logic [IN_W-1:0] v;
    v = vecs[id];
    chk($sformatf("grant_%0d_ready", id), 32'(bus.req_ready), 32'(1 << id));
    tick();
    chk($sformatf("grant_%0d_busy", id), 32'(bus.busy), 32'd1);
    chk($sformatf("grant_%0d_core_in", id), 32'(bus.core_in), 32'(v));
    chk($sformatf("grant_%0d_ready_off", id), 32'(bus.req_ready), 32'd0);
    tick();
    chk($sformatf("grant_%0d_early_rsp", id), 32'(bus.rsp_valid), 32'd0);
    tick();
    chk($sformatf("grant_%0d_rsp_valid", id), 32'(bus.rsp_valid), 32'd1);
    chk($sformatf("grant_%0d_rsp_id", id), 32'(bus.rsp_id), 32'(id));
    chk($sformatf("grant_%0d_rsp_data", id), 32'(bus.rsp_data), 32'(frg(v)));
    tick();
    chk($sformatf("grant_%0d_rsp_done", id), 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    delay_mode    = 1'b0;
    bus.req_valid = '0;
    bus.req_vec   = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) vecs[i] = '0;
    tick();
    tick();
    chk("rst_core_in", 32'(bus.core_in), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single request from requester 2
    vecs[2] = 28'h0000001;
    apply_vecs();
    bus.req_valid = 4'b0100;
    #1;
    chk("single_ready", 32'(bus.req_ready), 32'b0100);
    chk("single_idle_busy", 32'(bus.busy), 32'd0);
    tick();
    bus.req_valid = 4'b0000;
    chk("single_busy", 32'(bus.busy), 32'd1);
    chk("single_core_in", 32'(bus.core_in), 32'h0000001);
    tick();
    chk("single_c2_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    chk("single_c3_valid", 32'(bus.rsp_valid), 32'd1);
    chk("single_c3_id", 32'(bus.rsp_id), 32'd2);
    chk("single_c3_data", 32'(bus.rsp_data), 32'(frg(28'h0000001)));
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("single_done_valid", 32'(bus.rsp_valid), 32'd0);
    chk("single_done_busy", 32'(bus.busy), 32'd0);

    // Reset asserted mid-WAIT; pointer at 3 so requester 0 wins after wrap
    vecs[0] = 28'h0ABCDEF;
    apply_vecs();
    bus.req_valid = 4'b0001;
    #1;
    chk("wait_ready", 32'(bus.req_ready), 32'b0001);
    tick();
    chk("wait_core_in", 32'(bus.core_in), 32'h0ABCDEF);
    chk("wait_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_core_in", 32'(bus.core_in), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("midrst_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    chk("postrst_busy", 32'(bus.busy), 32'd0);

    // Round robin with every requester valid: 0,1,2,3,0 at a 4-cycle period
    vecs[0] = 28'h0123456;
    vecs[1] = 28'h0FEDCBA;
    vecs[2] = 28'h00F00F0;
    vecs[3] = 28'h0A5A5A5;
    apply_vecs();
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    #1;
    for (int g = 0; g < 5; g++) txn(g % NREQ);

    // Pointer now 1: only 3 requesting, then wrap to 0 and skip to 1
    bus.req_valid = 4'b1000;
    #1;
    txn(3);
    bus.req_valid = 4'b0010;
    #1;
    txn(1);

    // Backpressure with requesters 0 and 1 valid; pointer 2 wraps to 0
    vecs[0] = 28'h0000003;
    vecs[1] = 28'h0FF1F00;
    apply_vecs();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b0011;
    #1;
    chk("bp_grant", 32'(bus.req_ready), 32'b0001);
    tick();
    tick();
    tick();
    chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("bp_rsp_id", 32'(bus.rsp_id), 32'd0);
    chk("bp_rsp_data", 32'(bus.rsp_data), 32'(frg(28'h0000003)));
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_hold_id", 32'(bus.rsp_id), 32'd0);
      chk("bp_hold_data", 32'(bus.rsp_data), 32'(frg(28'h0000003)));
      chk("bp_hold_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_hold_core_in", 32'(bus.core_in), 32'h0000003);
    end
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_release_valid", 32'(bus.rsp_valid), 32'd0);

    // Settle: core output lags core_in by one cycle; result must be vector 1's, not vector 0's
    delay_mode = 1'b1;
    #1;
    txn(1);

    bus.req_valid = 4'b0000;
    bus.rsp_ready = 1'b0;
    tick();
    chk("end_idle_busy", 32'(bus.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
